// File: rtl/lv_bist_pkg.sv
// Shared types and defaults for the LV logic BIST sequencer.
package lv_bist_pkg;
    `include "lv_param.svh"

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_EVAL,
        ST_GAP,
        ST_REPORT
    } bist_state_e;

    localparam int RSLT_SCAN = 0;
    localparam int RSLT_OWT  = 1;
    localparam int RSLT_INTB = 2;
    localparam int RSLT_TMO  = 3;

    localparam int DEF_BIST_DONE_TMO_TH = 2100 * CLK_M;
    localparam int DEF_BIST_GAP_CYC     = 16;
    localparam int DEF_BIST_RETRY_NUM   = 1;
endpackage

// File: rtl/lv_param.svh
// Shared platform constants for the LV BIST blocks.
`ifndef LV_PARAM_SVH
`define LV_PARAM_SVH
localparam int CLK_M = 16;  // core clock in MHz; the timeout default scales with it
`endif

// File: rtl/lv_bist_ctrl.sv
// LV logic BIST sequencer: runs the engine, evaluates fail flags, retries
// after a low gap and reports a one-cycle verdict.
module lv_bist_ctrl
    import lv_bist_pkg::*;
#(
    parameter int BIST_DONE_TMO_TH = DEF_BIST_DONE_TMO_TH,
    parameter int BIST_GAP_CYC     = DEF_BIST_GAP_CYC,
    parameter int BIST_RETRY_NUM   = DEF_BIST_RETRY_NUM
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_bist_start,
    input  logic       i_bist_abort,
    output logic       o_bist_en,
    input  logic       i_lv_bist_done,
    input  logic       i_scan_reg_bist_rult,
    input  logic       i_owt_bist_rult,
    input  logic       i_hv_intb_bist_rult,
    output logic       o_bist_busy,
    output logic       o_bist_fin,
    output logic       o_bist_pass,
    output logic [3:0] o_bist_rslt,
    output logic [1:0] o_bist_try_cnt
);
    // One register serves as timeout counter in RUN and gap counter in GAP.
    localparam int CNT_MAX = (BIST_DONE_TMO_TH > BIST_GAP_CYC) ? BIST_DONE_TMO_TH : BIST_GAP_CYC;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(BIST_DONE_TMO_TH - 1);
    // EVAL is the first low cycle of the inter-attempt gap, so GAP itself
    // lasts one cycle less than the full low time.
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((BIST_GAP_CYC > 2) ? BIST_GAP_CYC - 2 : 0);

    bist_state_e      state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            o_bist_en      <= 1'b0;
            o_bist_busy    <= 1'b0;
            o_bist_fin     <= 1'b0;
            o_bist_pass    <= 1'b0;
            o_bist_rslt    <= '0;
            o_bist_try_cnt <= '0;
        end else begin
            o_bist_fin <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_bist_start && !i_bist_abort) begin
                        state          <= ST_RUN;
                        cnt            <= '0;
                        o_bist_en      <= 1'b1;
                        o_bist_busy    <= 1'b1;
                        o_bist_pass    <= 1'b0;
                        o_bist_rslt    <= '0;
                        o_bist_try_cnt <= 2'd1;
                    end
                end
                ST_RUN: begin
                    if (i_bist_abort) begin
                        state       <= ST_IDLE;
                        o_bist_en   <= 1'b0;
                        o_bist_busy <= 1'b0;
                        o_bist_pass <= 1'b0;
                    end else if (i_lv_bist_done) begin
                        // Done beats a coincident timeout.
                        state                 <= ST_EVAL;
                        o_bist_en             <= 1'b0;
                        o_bist_rslt[RSLT_SCAN] <= i_scan_reg_bist_rult;
                        o_bist_rslt[RSLT_OWT]  <= i_owt_bist_rult;
                        o_bist_rslt[RSLT_INTB] <= i_hv_intb_bist_rult;
                        o_bist_rslt[RSLT_TMO]  <= 1'b0;
                    end else if (cnt == TMO_LAST) begin
                        state       <= ST_EVAL;
                        o_bist_en   <= 1'b0;
                        o_bist_rslt <= 4'b1000;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_EVAL: begin
                    if (i_bist_abort) begin
                        state       <= ST_IDLE;
                        o_bist_busy <= 1'b0;
                        o_bist_pass <= 1'b0;
                    end else if (o_bist_rslt == 4'd0) begin
                        state       <= ST_REPORT;
                        o_bist_fin  <= 1'b1;
                        o_bist_pass <= 1'b1;
                    end else if (int'(o_bist_try_cnt) <= BIST_RETRY_NUM) begin
                        state <= ST_GAP;
                        cnt   <= '0;
                    end else begin
                        state       <= ST_REPORT;
                        o_bist_fin  <= 1'b1;
                        o_bist_pass <= 1'b0;
                    end
                end
                ST_GAP: begin
                    if (i_bist_abort) begin
                        state       <= ST_IDLE;
                        o_bist_busy <= 1'b0;
                        o_bist_pass <= 1'b0;
                    end else if (cnt == GAP_LAST) begin
                        state     <= ST_RUN;
                        cnt       <= '0;
                        o_bist_en <= 1'b1;
                        if (o_bist_try_cnt != 2'd3) begin
                            o_bist_try_cnt <= o_bist_try_cnt + 2'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_REPORT: begin
                    state       <= ST_IDLE;
                    o_bist_busy <= 1'b0;
                end
                default: begin
                    state       <= ST_IDLE;
                    o_bist_en   <= 1'b0;
                    o_bist_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lv_bist_ctrl.sv
// Bench for lv_bist_ctrl: a responder emulates the BIST engine, a model
// predicts each sequence and a monitor checks enable widths and verdicts.
module tb_lv_bist_ctrl;
    localparam int TH    = 200;
    localparam int GAP   = 4;
    localparam int RETRY = 1;
    localparam int NATT  = RETRY + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_bist_start = 1'b0;
    logic       i_bist_abort = 1'b0;
    logic       i_lv_bist_done = 1'b0;
    logic [2:0] flags = 3'd0;
    logic       o_bist_en, o_bist_busy, o_bist_fin, o_bist_pass;
    logic [3:0] o_bist_rslt;
    logic [1:0] o_bist_try_cnt;

    lv_bist_ctrl #(
        .BIST_DONE_TMO_TH(TH),
        .BIST_GAP_CYC    (GAP),
        .BIST_RETRY_NUM  (RETRY)
    ) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_bist_start        (i_bist_start),
        .i_bist_abort        (i_bist_abort),
        .o_bist_en           (o_bist_en),
        .i_lv_bist_done      (i_lv_bist_done),
        .i_scan_reg_bist_rult(flags[0]),
        .i_owt_bist_rult     (flags[1]),
        .i_hv_intb_bist_rult (flags[2]),
        .o_bist_busy         (o_bist_busy),
        .o_bist_fin          (o_bist_fin),
        .o_bist_pass         (o_bist_pass),
        .o_bist_rslt         (o_bist_rslt),
        .o_bist_try_cnt      (o_bist_try_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard queues: verdict {pass, rslt, try_cnt} and enable-high widths.
    logic [6:0] exp_q[$];
    int         len_q[$];

    // Engine configuration per attempt: done after dly enable cycles (0 = never).
    int         att_dly[NATT];
    logic [2:0] att_flg[NATT];
    int         att_idx = 0;

    // Engine responder.
    int r_hi = 0;
    bit r_prev = 1'b0;
    always @(negedge clk) begin
        if (o_bist_en) begin
            r_hi = r_prev ? r_hi + 1 : 1;
            if (att_idx < NATT && att_dly[att_idx] == r_hi) begin
                i_lv_bist_done = 1'b1;
                flags          = att_flg[att_idx];
            end else begin
                i_lv_bist_done = 1'b0;
                flags          = 3'($urandom_range(0, 7));
            end
        end else begin
            if (r_prev) att_idx++;
            i_lv_bist_done = 1'b0;
            flags          = 3'($urandom_range(0, 7));
        end
        r_prev = o_bist_en;
    end

    // Monitor.
    int m_hi = 0;
    int m_low = 0;
    bit m_prev = 1'b0;
    bit m_low_busy = 1'b0;
    always @(negedge clk) begin
        if (o_bist_en && !m_prev) begin
            if (m_low_busy) chk("gap_low_cycles", m_low, GAP);
            m_hi = 1;
        end else if (o_bist_en) begin
            m_hi++;
        end else if (m_prev) begin
            if (len_q.size() == 0) chk("en_len_unexpected", m_hi, -1);
            else chk("en_high_cycles", m_hi, len_q.pop_front());
            m_low = 1;
            m_low_busy = o_bist_busy;
        end else begin
            m_low++;
            m_low_busy = m_low_busy & o_bist_busy;
        end
        if (o_bist_fin) begin
            chk("fin_latency", m_low, 2);
            if (exp_q.size() == 0) chk("fin_unexpected", 1, 0);
            else chk("verdict", int'({o_bist_pass, o_bist_rslt, o_bist_try_cnt}), int'(exp_q.pop_front()));
        end
        m_prev = o_bist_en;
    end

    // Reference model: predict each attempt from the engine configuration.
    task automatic model_push(input bit with_report);
        int tries;
        logic [3:0] r;
        tries = 0;
        r = 4'd0;
        for (int k = 0; k < NATT; k++) begin
            tries++;
            if (att_dly[k] >= 1 && att_dly[k] <= TH) begin
                len_q.push_back(att_dly[k]);
                r = {1'b0, att_flg[k]};
            end else begin
                len_q.push_back(TH);
                r = 4'b1000;
            end
            if (r == 4'd0 || tries > RETRY) break;
        end
        if (with_report) exp_q.push_back({r == 4'd0, r, (tries > 3) ? 2'd3 : 2'(tries)});
    endtask

    task automatic set_att(input int d0, input logic [2:0] f0, input int d1, input logic [2:0] f1);
        att_dly[0] = d0; att_flg[0] = f0;
        att_dly[1] = d1; att_flg[1] = f1;
        att_idx = 0;
    endtask

    // Called on a negedge while idle; returns on a negedge once busy drops.
    task automatic run_seq(input bit stray);
        bit done;
        done = 1'b0;
        model_push(1'b1);
        i_bist_start = 1'b1;
        @(negedge clk);
        i_bist_start = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            i_bist_start = (stray && c == 1);
            if (!o_bist_busy) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        i_bist_start = 1'b0;
        if (!done) chk("sequence_timeout", 0, 1);
        @(negedge clk);
    endtask

    function automatic int pick_dly();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 0;
        if (r == 1) return TH;
        if (r == 2) return 1;
        return $urandom_range(1, 60);
    endfunction

    function automatic logic [2:0] pick_flg();
        return ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
    endfunction

    initial begin
        bit seen;
        set_att(0, 3'd0, 0, 3'd0);
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({o_bist_en, o_bist_busy, o_bist_fin, o_bist_pass, o_bist_rslt, o_bist_try_cnt}), 0);
        rst = 1'b0;
        @(negedge clk);

        set_att(50, 3'd0, 0, 3'd0);    run_seq(1'b0);  // single pass
        set_att(37, 3'b010, 23, 3'd0); run_seq(1'b0);  // owt fail then pass
        set_att(0, 3'd0, 0, 3'd0);     run_seq(1'b0);  // two timeouts
        set_att(TH, 3'd0, 0, 3'd0);    run_seq(1'b0);  // done on last counter value
        set_att(12, 3'b101, 9, 3'b100); run_seq(1'b1); // fail twice, stray start

        // Abort after 30 enable cycles, then start+abort together in IDLE.
        set_att(0, 3'd0, 0, 3'd0);
        len_q.push_back(30);
        i_bist_start = 1'b1;
        @(negedge clk);
        i_bist_start = 1'b0;
        repeat (29) @(negedge clk);
        i_bist_abort = 1'b1;
        @(negedge clk);
        chk("abort_ctrl", int'({o_bist_en, o_bist_busy, o_bist_fin, o_bist_pass}), 0);
        chk("abort_rslt", int'(o_bist_rslt), 0);
        i_bist_start = 1'b1;
        @(negedge clk);
        i_bist_start = 1'b0;
        i_bist_abort = 1'b0;
        chk("start_abort_idle", int'({o_bist_en, o_bist_busy}), 0);
        repeat (4) @(negedge clk);

        // Reset during the gap between attempts.
        set_att(20, 3'b001, 0, 3'd0);
        len_q.push_back(20);
        i_bist_start = 1'b1;
        @(negedge clk);
        i_bist_start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (!o_bist_en) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) chk("gap_wait_timeout", 0, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("reset_in_gap", int'({o_bist_en, o_bist_busy, o_bist_fin, o_bist_pass, o_bist_rslt, o_bist_try_cnt}), 0);
        repeat (GAP + 2) @(negedge clk);
        chk("no_retry_after_reset", int'({o_bist_en, o_bist_busy}), 0);
        set_att(44, 3'd0, 0, 3'd0); run_seq(1'b0);

        for (int i = 0; i < 20; i++) begin
            set_att(pick_dly(), pick_flg(), pick_dly(), pick_flg());
            run_seq(1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        chk("verdicts_left", exp_q.size(), 0);
        chk("lengths_left", len_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/lv_bist_ctrl.md
LV_BIST_CTRL -- requirements
Module: lv_bist_ctrl

Interface
REQ-001 Parameter BIST_DONE_TMO_TH, default 2100*CLK_M, cycles allowed from o_bist_en rise to i_lv_bist_done before timeout.
REQ-002 Parameter BIST_GAP_CYC, default 16, cycles o_bist_en is held low between attempts.
REQ-003 Parameter BIST_RETRY_NUM, default 1, extra attempts after a failed attempt.
REQ-004 Port list (name, direction, width, meaning):
- i_clk  in  1  sole clock; one clock, all logic on its rising edge.
- i_rst  in  1  reset; synchronous and active-high.
- i_bist_start  in  1  start request pulse from mode control.
- i_bist_abort  in  1  abort request.
- o_bist_en  out  1  enable to the LV logic BIST engine.
- i_lv_bist_done  in  1  engine done level.
- i_scan_reg_bist_rult  in  1  scan-register fail flag.
- i_owt_bist_rult  in  1  OWT fail flag.
- i_hv_intb_bist_rult  in  1  HV INTB fail flag.
- o_bist_busy  out  1  sequence in progress.
- o_bist_fin  out  1  one-cycle completion pulse.
- o_bist_pass  out  1  final verdict, 1 = pass.
- o_bist_rslt  out  4  {tmo, intb, owt, scan} fail bits of the last attempt.
- o_bist_try_cnt  out  2  attempts started in the current sequence.

Function
REQ-005 FSM states: IDLE, RUN, EVAL, GAP, REPORT.
REQ-006 IDLE: i_bist_start=1 and i_bist_abort=0 -> RUN next cycle; clear o_bist_rslt and o_bist_pass; set o_bist_try_cnt=1.
REQ-007 o_bist_en is registered and equals 1 exactly while the state is RUN; its first high cycle is the cycle after start is accepted.
REQ-008 RUN: a timeout counter increments from 0 each cycle.
REQ-009 RUN, i_lv_bist_done=1 -> EVAL; capture the three fail inputs into o_bist_rslt[2:0]; set tmo=0.
REQ-010 RUN, counter reaches BIST_DONE_TMO_TH-1 without done -> EVAL; set o_bist_rslt=4'b1000.
REQ-011 When done and timeout coincide in the same cycle, done wins.
REQ-012 EVAL (one cycle): o_bist_rslt==0 -> REPORT with pass.
REQ-013 EVAL: fail and o_bist_try_cnt<=BIST_RETRY_NUM -> GAP.
REQ-014 EVAL: any other fail -> REPORT with fail.
REQ-015 GAP: o_bist_en stays low for BIST_GAP_CYC cycles so the engine clears its counters; then -> RUN, increment o_bist_try_cnt, clear the timeout counter.
REQ-016 o_bist_try_cnt saturates at 3.
REQ-017 REPORT (one cycle): o_bist_fin=1; o_bist_pass=(o_bist_rslt==0); -> IDLE.
REQ-018 o_bist_pass and o_bist_rslt hold until the next accepted start or reset.
REQ-019 o_bist_busy=1 in RUN, EVAL, GAP, REPORT.
REQ-020 i_bist_start outside IDLE is ignored.
REQ-021 Start and abort in the same IDLE cycle: abort wins and start is ignored.
REQ-022 i_bist_abort in RUN, EVAL or GAP -> IDLE next cycle; o_bist_en low; no o_bist_fin pulse; o_bist_pass=0; o_bist_rslt keeps its current value.
REQ-023 Abort in REPORT is ignored and the report completes.
REQ-024 Timeout counter width is $clog2(BIST_DONE_TMO_TH); it never wraps.

Reset
REQ-025 i_rst=1 at a clock edge: state=IDLE, all counters 0, o_bist_en=0, o_bist_busy=0, o_bist_fin=0, o_bist_pass=0, o_bist_rslt=0, o_bist_try_cnt=0.
REQ-026 Reset mid-sequence drops o_bist_en on the same edge and produces no o_bist_fin.

Structure
REQ-027 Package lv_bist_pkg holds the state enum, the o_bist_rslt bit indices (SCAN=0, OWT=1, INTB=2, TMO=3) and the default values of the three parameters; CLK_M comes from lv_param.svh.
REQ-028 Single module with no sub-module; the timeout and gap counters share one counter register.

Verification (BIST_DONE_TMO_TH=200, BIST_GAP_CYC=4, BIST_RETRY_NUM=1)
REQ-029 Start pulse, done after 50 cycles with all flags 0 -> o_bist_en high 50 cycles, o_bist_fin pulse 2 cycles after done, o_bist_pass=1, o_bist_rslt=0, o_bist_try_cnt=1.
REQ-030 owt flag=1 on the 1st done, all flags 0 on the 2nd done -> o_bist_en low exactly 4 cycles between attempts, o_bist_try_cnt=2, o_bist_pass=1.
REQ-031 Done never asserted -> two attempts of 200 cycles each, o_bist_pass=0, o_bist_rslt=4'b1000.
REQ-032 Done and counter at 199 in the same cycle, flags 0 -> pass with tmo=0.
REQ-033 Abort at cycle 30 of RUN, then a start in the same cycle as an abort in IDLE -> o_bist_en low next cycle, no o_bist_fin, no new sequence.
REQ-034 i_rst asserted for 1 cycle during GAP -> all outputs 0 next cycle; a new start then runs normally.
